// File: rtl/fp_op_sequencer_pkg.sv
// Shared types and defaults for the FPALU multicycle sequencer:
// FPALU op codes, sequencer state encoding and default op-class latencies.
package fp_op_sequencer_pkg;

  typedef enum logic [4:0] {
    FOPADD   = 5'd0,
    FOPSUB   = 5'd1,
    FOPMUL   = 5'd2,
    FOPDIV   = 5'd3,
    FOPSQRT  = 5'd4,
    FOPMIN   = 5'd5,
    FOPMAX   = 5'd6,
    FOPSGNJ  = 5'd7,
    FOPSGNJN = 5'd8,
    FOPSGNJX = 5'd9,
    FOPCVTWS = 5'd10,
    FOPCVTSW = 5'd11,
    FOPEQ    = 5'd12,
    FOPLT    = 5'd13,
    FOPLE    = 5'd14,
    FOPMV    = 5'd15
  } fp_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_WB    = 2'd3
  } seq_state_e;

  localparam int LAT_ADD_DEF  = 7;
  localparam int LAT_MUL_DEF  = 5;
  localparam int LAT_DIV_DEF  = 6;
  localparam int LAT_SQRT_DEF = 16;
  localparam int LAT_CVT_DEF  = 6;
  localparam int LAT_MISC_DEF = 1;
  localparam int LAT_MAX      = 31;

endpackage

// File: rtl/fp_op_sequencer_if.sv
// Control-unit <-> FP sequencer signal bundle; master is the control unit side.
interface fp_op_sequencer_if;
  logic       iStart;
  logic [4:0] iOp;
  logic [4:0] iRd;
  logic       iDestInt;
  logic [4:0] oFPControl;
  logic       oFPStart;
  logic       oStall;
  logic       oFPRegWrite;
  logic       oIntRegWrite;
  logic [4:0] oWbRd;
  logic       oBusy;
  logic       oIllegal;

  modport master (
    output iStart, iOp, iRd, iDestInt,
    input  oFPControl, oFPStart, oStall, oFPRegWrite, oIntRegWrite, oWbRd, oBusy, oIllegal
  );

  modport slave (
    input  iStart, iOp, iRd, iDestInt,
    output oFPControl, oFPStart, oStall, oFPRegWrite, oIntRegWrite, oWbRd, oBusy, oIllegal
  );
endinterface

// File: rtl/fp_op_sequencer_fp_lat_lookup.sv
// Combinational op-code to FPALU latency map; op codes outside 0..15 are flagged illegal.
module fp_lat_lookup
  import fp_op_sequencer_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF,
  parameter int LAT_MISC = LAT_MISC_DEF
) (
  input  logic [4:0] op,
  output logic [4:0] latency,
  output logic       legal
);

  localparam logic [4:0] L_ADD  = LAT_ADD[4:0];
  localparam logic [4:0] L_MUL  = LAT_MUL[4:0];
  localparam logic [4:0] L_DIV  = LAT_DIV[4:0];
  localparam logic [4:0] L_SQRT = LAT_SQRT[4:0];
  localparam logic [4:0] L_CVT  = LAT_CVT[4:0];
  localparam logic [4:0] L_MISC = LAT_MISC[4:0];

  // The down-counter is 5 bits, so every class latency must fit in 1..31.
  generate
    if (LAT_ADD < 1 || LAT_ADD > LAT_MAX || LAT_MUL < 1 || LAT_MUL > LAT_MAX ||
        LAT_DIV < 1 || LAT_DIV > LAT_MAX || LAT_SQRT < 1 || LAT_SQRT > LAT_MAX ||
        LAT_CVT < 1 || LAT_CVT > LAT_MAX || LAT_MISC < 1 || LAT_MISC > LAT_MAX) begin : g_lat_range_error
      $error("fp_lat_lookup: every LAT_* parameter must be in 1..31");
    end
  endgenerate

  // Map each op code onto its class latency.
  always_comb begin
    latency = 5'd0;
    legal   = 1'b1;
    case (op)
      FOPADD, FOPSUB:                    latency = L_ADD;
      FOPMUL:                            latency = L_MUL;
      FOPDIV:                            latency = L_DIV;
      FOPSQRT:                           latency = L_SQRT;
      FOPCVTWS, FOPCVTSW:                latency = L_CVT;
      FOPMIN, FOPMAX, FOPSGNJ, FOPSGNJN,
      FOPSGNJX, FOPEQ, FOPLT, FOPLE,
      FOPMV:                             latency = L_MISC;
      default: begin
        latency = 5'd0;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// Multicycle FPALU sequencer: accepts a decoded FP op, stalls the PC, issues one
// start pulse, counts the op-class latency and emits a one-cycle writeback strobe.
module fp_op_sequencer
  import fp_op_sequencer_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF,
  parameter int LAT_MISC = LAT_MISC_DEF
) (
  input logic              iCLK,
  input logic              iRST_n,
  fp_op_sequencer_if.slave seq
);

  seq_state_e state_r;
  logic [4:0] op_r;
  logic [4:0] rd_r;
  logic [4:0] lat_r;
  logic [4:0] cnt_r;
  logic       dest_int_r;
  logic       fp_start_r;
  logic       stall_r;
  logic       fp_wr_r;
  logic       int_wr_r;
  logic       busy_r;
  logic [4:0] lat_s;
  logic       legal_s;
  logic       idle_start_s;
  logic       accept_s;

  fp_lat_lookup #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
    .LAT_CVT  (LAT_CVT),
    .LAT_MISC (LAT_MISC)
  ) u_lat (
    .op      (seq.iOp),
    .latency (lat_s),
    .legal   (legal_s)
  );

  assign idle_start_s = (state_r == SEQ_IDLE) && seq.iStart;
  assign accept_s     = idle_start_s && legal_s;

  // Sequencer FSM with latency counter; strobes are registered on state entry.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r    <= SEQ_IDLE;
      op_r       <= 5'd0;
      rd_r       <= 5'd0;
      lat_r      <= 5'd0;
      cnt_r      <= 5'd0;
      dest_int_r <= 1'b0;
      fp_start_r <= 1'b0;
      stall_r    <= 1'b0;
      fp_wr_r    <= 1'b0;
      int_wr_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      fp_start_r <= 1'b0;
      fp_wr_r    <= 1'b0;
      int_wr_r   <= 1'b0;
      case (state_r)
        SEQ_IDLE: begin
          if (accept_s) begin
            op_r       <= seq.iOp;
            rd_r       <= seq.iRd;
            dest_int_r <= seq.iDestInt;
            lat_r      <= lat_s;
            state_r    <= SEQ_ISSUE;
            fp_start_r <= 1'b1;
            stall_r    <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            stall_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        SEQ_ISSUE: begin
          cnt_r <= lat_r - 5'd1;
          if (lat_r == 5'd1) begin
            state_r  <= SEQ_WB;
            stall_r  <= 1'b0;
            fp_wr_r  <= ~dest_int_r;
            int_wr_r <= dest_int_r;
          end else begin
            state_r <= SEQ_WAIT;
          end
        end
        SEQ_WAIT: begin
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            state_r  <= SEQ_WB;
            stall_r  <= 1'b0;
            fp_wr_r  <= ~dest_int_r;
            int_wr_r <= dest_int_r;
          end else begin
            state_r <= SEQ_WAIT;
          end
        end
        SEQ_WB: begin
          // The instruction that caused this op is still decoded here, so iStart is ignored.
          state_r <= SEQ_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= SEQ_IDLE;
          stall_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // In IDLE the stall must act in the decode cycle itself, hence the combinational term.
  assign seq.oStall       = iRST_n && (stall_r || accept_s);
  assign seq.oIllegal     = iRST_n && idle_start_s && !legal_s;
  assign seq.oFPControl   = op_r;
  assign seq.oWbRd        = rd_r;
  assign seq.oFPStart     = fp_start_r;
  assign seq.oFPRegWrite  = fp_wr_r;
  assign seq.oIntRegWrite = int_wr_r;
  assign seq.oBusy        = busy_r;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Randomised self-checking bench for fp_op_sequencer against a cycle-offset timeline model.
module tb_fp_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   last_op = 0;
  int   last_rd = 0;

  always #5 clk = ~clk;

  fp_op_sequencer_if bus ();

  fp_op_sequencer dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .seq    (bus.slave)
  );

  // Latency of each op class; 0 marks an unmapped op code.
  function automatic int ref_lat(input int op);
    if (op == 0 || op == 1) return 7;
    if (op == 2) return 5;
    if (op == 3) return 6;
    if (op == 4) return 16;
    if (op == 10 || op == 11) return 6;
    if (op >= 5 && op <= 15) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " stall"}, 32'(bus.oStall), 32'd0);
    check({tag, " start"}, 32'(bus.oFPStart), 32'd0);
    check({tag, " fpwr"}, 32'(bus.oFPRegWrite), 32'd0);
    check({tag, " intwr"}, 32'(bus.oIntRegWrite), 32'd0);
    check({tag, " busy"}, 32'(bus.oBusy), 32'd0);
    check({tag, " illegal"}, 32'(bus.oIllegal), 32'd0);
  endtask

  // One accepted op: cycle k=0 is the iStart cycle, WB is expected at k=L+1.
  task automatic run_op(input int op, input int rd, input bit dest, input bit hold);
    int lat;
    int stalls;
    int wbs;
    string t;
    lat = ref_lat(op);
    stalls = 0;
    wbs = 0;
    @(posedge clk); #1;
    bus.iStart = 1'b1;
    bus.iOp = 5'(op);
    bus.iRd = 5'(rd);
    bus.iDestInt = dest;
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (!hold) begin
          bus.iStart = 1'b0;
          bus.iOp = 5'($urandom);
          bus.iRd = 5'($urandom);
          bus.iDestInt = 1'($urandom);
        end
      end
      @(negedge clk);
      t = $sformatf("op%0d k%0d", op, k);
      check({t, " stall"}, 32'(bus.oStall), 32'(k <= lat));
      check({t, " start"}, 32'(bus.oFPStart), 32'(k == 1));
      check({t, " fpwr"}, 32'(bus.oFPRegWrite), 32'(k == lat + 1 && !dest));
      check({t, " intwr"}, 32'(bus.oIntRegWrite), 32'(k == lat + 1 && dest));
      check({t, " busy"}, 32'(bus.oBusy), 32'(k >= 1));
      check({t, " illegal"}, 32'(bus.oIllegal), 32'd0);
      if (k >= 1) begin
        check({t, " ctrl"}, 32'(bus.oFPControl), 32'(op));
        check({t, " rd"}, 32'(bus.oWbRd), 32'(rd));
      end
      stalls += int'(bus.oStall);
      wbs += int'(bus.oFPRegWrite) + int'(bus.oIntRegWrite);
    end
    check($sformatf("op%0d stall_total", op), 32'(stalls), 32'(lat + 1));
    check($sformatf("op%0d wb_total", op), 32'(wbs), 32'd1);
    last_op = op;
    last_rd = rd;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    @(negedge clk);
    check_quiet("idle");
    check("idle ctrl_hold", 32'(bus.oFPControl), 32'(last_op));
    check("idle rd_hold", 32'(bus.oWbRd), 32'(last_rd));
  endtask

  task automatic illegal_op(input int op);
    @(posedge clk); #1;
    bus.iStart = 1'b1;
    bus.iOp = 5'(op);
    bus.iRd = 5'($urandom);
    @(negedge clk);
    check($sformatf("ill%0d pulse", op), 32'(bus.oIllegal), 32'd1);
    check($sformatf("ill%0d stall", op), 32'(bus.oStall), 32'd0);
    check($sformatf("ill%0d busy", op), 32'(bus.oBusy), 32'd0);
    check($sformatf("ill%0d start", op), 32'(bus.oFPStart), 32'd0);
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    @(negedge clk);
    check_quiet($sformatf("ill%0d after", op));
    check($sformatf("ill%0d ctrl_hold", op), 32'(bus.oFPControl), 32'(last_op));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    bus.iStart = 1'b0;
    bus.iOp = 5'd0;
    bus.iRd = 5'd0;
    bus.iDestInt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset ctrl", 32'(bus.oFPControl), 32'd0);
    check("reset rd", 32'(bus.oWbRd), 32'd0);
    rst_n = 1'b1;

    run_op(0, 3, 1'b0, 1'b0);
    idle_cycle();
    run_op(12, 10, 1'b1, 1'b0);
    idle_cycle();
    run_op(4, 7, 1'b0, 1'b1);
    run_op(2, 9, 1'b0, 1'b1);
    idle_cycle();
    illegal_op(20);
    idle_cycle();

    for (int i = 0; i < 16; i++) begin
      run_op(i, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 31));
      if (ref_lat(op) == 0) illegal_op(op);
      else run_op(op, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset in the middle of a DIV's wait phase.
    @(posedge clk); #1;
    bus.iStart = 1'b1;
    bus.iOp = 5'd3;
    bus.iRd = 5'd17;
    bus.iDestInt = 1'b0;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst mid busy_before", 32'(bus.oBusy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_quiet("rst mid");
    check("rst mid ctrl", 32'(bus.oFPControl), 32'd0);
    check("rst mid rd", 32'(bus.oWbRd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_op = 0;
    last_rd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_quiet($sformatf("post_rst k%0d", k));
    end
    run_op(3, 5, 1'b1, 1'b0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
